if_fetch_ctrl: RTL and testbench

Instruction-fetch controller directly around the PC register. It consumes the current PC and drives the PC's next value and freeze. It runs a req/ack handshake with a variable-latency instruction memory. It owns the IF/ID pipeline register, including stall hold, bubble insertion and branch flush.

---
 rtl/if_fetch_ctrl_pkg.sv | 18 +
 rtl/if_fetch_ctrl_if.sv | 28 ++
 rtl/if_fetch_ctrl_if_id_reg.sv | 70 +++++++
 rtl/if_fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_fetch_ctrl_pkg;

  localparam int unsigned DATA_LEN_DEF = 32;
  localparam int unsigned PC_STEP_DEF  = 4;

  // Fetch FSM states. The encoding is fixed so that debug dumps stay
  // readable across revisions.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request bus: req/addr out and ack/rdata back.
// Latency: variable; the memory answers with imem_ack whenever it is ready.
// Backpressure: req/addr are held stable by the master until imem_ack.
// Ports: master = fetch controller, slave = instruction memory.
interface if_fetch_ctrl_if #(
  parameter int unsigned DATA_LEN = 32
) ();

  logic                imem_req;
  logic [DATA_LEN-1:0] imem_addr;
  logic                imem_ack;
  logic [DATA_LEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register with flush, hold and load priority.
// Latency: one clock from a load request to the registered outputs.
// Backpressure: hold keeps all outputs frozen; no load -> bubble (valid=0).
// Ports: flush/hold/load_mem/load_buf controls, two candidate sources
//        (memory data + its PC, buffered data + its PC), registered outputs.
module if_fetch_ctrl_if_id_reg
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_LEN = DATA_LEN_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                hold,
  input  logic                load_mem,
  input  logic                load_buf,
  input  logic [DATA_LEN-1:0] mem_instr,
  input  logic [DATA_LEN-1:0] mem_pc,
  input  logic [DATA_LEN-1:0] buf_instr,
  input  logic [DATA_LEN-1:0] buf_pc,
  output logic [DATA_LEN-1:0] instr_out,
  output logic [DATA_LEN-1:0] pc_plus_out,
  output logic                valid_out
);

  logic [DATA_LEN-1:0] instr_q, instr_d;
  logic [DATA_LEN-1:0] pc_plus_q, pc_plus_d;
  logic                valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pc_plus_d = pc_plus_q;
    valid_d   = valid_q;
    if (flush) begin
      // pc_plus is left alone on flush; only the instruction is cleared.
      instr_d = '0;
      valid_d = 1'b0;
    end else if (hold) begin
      valid_d = valid_q;
    end else if (load_mem) begin
      instr_d   = mem_instr;
      pc_plus_d = mem_pc + DATA_LEN'(PC_STEP);
      valid_d   = 1'b1;
    end else if (load_buf) begin
      instr_d   = buf_instr;
      pc_plus_d = buf_pc + DATA_LEN'(PC_STEP);
      valid_d   = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q   <= '0;
      pc_plus_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_plus_q <= pc_plus_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_out   = instr_q;
  assign pc_plus_out = pc_plus_q;
  assign valid_out   = valid_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: next-PC, imem req/ack handshake, IF/ID register.
// Latency: instruction appears on instr_out one clock after the req&ack cycle.
// Backpressure: hazard stalls IF/ID; data arriving during a stall is parked in
//               a one-entry buffer and the PC stays frozen until release.
// Ports: clk/rst, pc_in -> pc_next/pc_freeze, branch_taken/branch_addr,
//        hazard, imem (master side of the memory bus), IF/ID outputs.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_LEN = DATA_LEN_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] pc_in,
  input  logic                branch_taken,
  input  logic [DATA_LEN-1:0] branch_addr,
  input  logic                hazard,
  if_fetch_ctrl_if.master     imem,
  output logic [DATA_LEN-1:0] pc_next,
  output logic                pc_freeze,
  output logic [DATA_LEN-1:0] instr_out,
  output logic [DATA_LEN-1:0] pc_plus_out,
  output logic                valid_out
);

  fetch_state_e        state_q, state_d;
  logic [DATA_LEN-1:0] req_addr_q, req_addr_d;
  logic [DATA_LEN-1:0] buf_instr_q, buf_instr_d;
  logic [DATA_LEN-1:0] buf_pc_q, buf_pc_d;
  logic                accept_mem;
  logic                accept_buf;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    accept_mem  = 1'b0;
    accept_buf  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // Remember the outstanding address so a branch can keep it alive.
        req_addr_d = pc_in;
        if (imem.imem_ack) begin
          if (branch_taken) begin
            state_d = S_REQ;
          end else if (hazard) begin
            // PC is frozen, so pc_in is still this instruction's address.
            buf_instr_d = imem.imem_rdata;
            buf_pc_d    = pc_in;
            state_d     = S_FULL;
          end else begin
            accept_mem = 1'b1;
          end
        end else if (branch_taken) begin
          state_d = S_DROP;
        end
      end
      S_FULL: begin
        if (branch_taken) begin
          state_d = S_REQ;
        end else if (!hazard) begin
          accept_buf = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        // The stale response is consumed here and thrown away.
        if (imem.imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  // A buffer release advances the PC too; otherwise S_REQ would re-fetch
  // the instruction that was just handed over.
  assign pc_next   = branch_taken ? branch_addr : (pc_in + DATA_LEN'(PC_STEP));
  assign pc_freeze = ~(branch_taken | accept_mem | accept_buf);

  assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem.imem_addr = (state_q == S_REQ)  ? pc_in :
                          (state_q == S_DROP) ? req_addr_q : '0;

  if_fetch_ctrl_if_id_reg #(
    .DATA_LEN (DATA_LEN),
    .PC_STEP  (PC_STEP)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (branch_taken),
    .hold        (hazard),
    .load_mem    (accept_mem),
    .load_buf    (accept_buf),
    .mem_instr   (imem.imem_rdata),
    .mem_pc      (pc_in),
    .buf_instr   (buf_instr_q),
    .buf_pc      (buf_pc_q),
    .instr_out   (instr_out),
    .pc_plus_out (pc_plus_out),
    .valid_out   (valid_out)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: directed scenarios plus a randomized run
// against a program-order fetch model with a variable-latency memory.
// The bench owns the PC register and the instruction memory.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        hazard;
  logic [31:0] pc_next;
  logic        pc_freeze;
  logic [31:0] instr_out;
  logic [31:0] pc_plus_out;
  logic        valid_out;

  int total = 0;
  int bad   = 0;

  if_fetch_ctrl_if #(.DATA_LEN(32)) imem_bus ();

  if_fetch_ctrl #(.DATA_LEN(32), .PC_STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .hazard       (hazard),
    .imem         (imem_bus),
    .pc_next      (pc_next),
    .pc_freeze    (pc_freeze),
    .instr_out    (instr_out),
    .pc_plus_out  (pc_plus_out),
    .valid_out    (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // Inputs for the coming cycle; ack only answers a live request.
  task automatic drive(input logic hz, input logic br, input logic [31:0] ba, input logic ack);
    hazard       = hz;
    branch_taken = br;
    branch_addr  = ba;
    #1;
    imem_bus.imem_ack   = ack & imem_bus.imem_req;
    imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
    #1;
  endtask

  // Clock edge with the bench-side PC register update.
  task automatic tick();
    logic [31:0] nxt;
    nxt = pc_freeze ? pc : pc_next;
    @(posedge clk);
    #1;
    pc = nxt;
  endtask

  task automatic do_reset();
    rst = 1'b0; pc = 32'h0; hazard = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc = 32'h0; hazard = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", valid_out); end
    total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_out); end
    total++; if (pc_plus_out !== 32'h0) begin bad++; $display("FAIL rst_pcplus got=%h exp=0", pc_plus_out); end
    total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h exp=0", imem_bus.imem_req); end
    rst = 1'b1;
  endtask

  task automatic test_zero_wait();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%h exp=0", imem_bus.imem_req); end
    total++; if (pc_freeze !== 1'b1) begin bad++; $display("FAIL idle_freeze got=%h exp=1", pc_freeze); end
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'(k) * 32'd4;
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      total++; if (imem_bus.imem_addr !== a) begin bad++; $display("FAIL zw_addr got=%h exp=%h", imem_bus.imem_addr, a); end
      total++; if (pc_freeze !== 1'b0) begin bad++; $display("FAIL zw_freeze got=%h exp=0", pc_freeze); end
      tick();
      total++; if (instr_out !== mem_word(a)) begin bad++; $display("FAIL zw_instr got=%h exp=%h", instr_out, mem_word(a)); end
      total++; if (pc_plus_out !== a + 32'd4) begin bad++; $display("FAIL zw_pcplus got=%h exp=%h", pc_plus_out, a + 32'd4); end
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL zw_valid got=%h exp=1", valid_out); end
    end
  endtask

  task automatic test_latency();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 32'h0, c == 2);
      total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h10) begin
        bad++; $display("FAIL lat_req got=%h/%h exp=1/00000010", imem_bus.imem_req, imem_bus.imem_addr); end
      total++; if (pc_freeze !== (c != 2)) begin bad++; $display("FAIL lat_freeze c=%0d got=%h exp=%h", c, pc_freeze, c != 2); end
      tick();
      total++; if (valid_out !== (c == 2)) begin bad++; $display("FAIL lat_valid c=%0d got=%h exp=%h", c, valid_out, c == 2); end
    end
    total++; if (instr_out !== mem_word(32'h10) || pc_plus_out !== 32'h14) begin
      bad++; $display("FAIL lat_data got=%h/%h exp=%h/00000014", instr_out, pc_plus_out, mem_word(32'h10)); end
  endtask

  task automatic test_hazard_buffer();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 32'h0, c == 1);
      total++; if (pc_freeze !== 1'b1) begin bad++; $display("FAIL hz_freeze c=%0d got=%h exp=1", c, pc_freeze); end
      if (c >= 2) begin
        total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL hz_full_req got=%h exp=0", imem_bus.imem_req); end
      end
      tick();
      total++; if (valid_out !== 1'b1 || instr_out !== mem_word(32'h10) || pc_plus_out !== 32'h14) begin
        bad++; $display("FAIL hz_hold c=%0d got=%h/%h/%h", c, valid_out, instr_out, pc_plus_out); end
      total++; if (pc !== 32'h14) begin bad++; $display("FAIL hz_pc got=%h exp=00000014", pc); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    total++; if (pc_freeze !== 1'b0 || pc_next !== 32'h18) begin
      bad++; $display("FAIL hz_release got=%h/%h exp=0/00000018", pc_freeze, pc_next); end
    tick();
    total++; if (valid_out !== 1'b1 || instr_out !== mem_word(32'h14) || pc_plus_out !== 32'h18) begin
      bad++; $display("FAIL hz_buf got=%h/%h/%h exp=1/%h/00000018", valid_out, instr_out, pc_plus_out, mem_word(32'h14)); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (imem_bus.imem_addr !== 32'h18) begin bad++; $display("FAIL hz_next_addr got=%h exp=00000018", imem_bus.imem_addr); end
    tick();
    total++; if (instr_out !== mem_word(32'h18) || pc !== 32'h1C) begin
      bad++; $display("FAIL hz_after got=%h/%h exp=%h/0000001c", instr_out, pc, mem_word(32'h18)); end
  endtask

  task automatic test_branch_wait();
    pc = 32'h20;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL bw_bubble got=%h exp=0", valid_out); end
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    total++; if (pc_next !== 32'h100 || pc_freeze !== 1'b0) begin
      bad++; $display("FAIL bw_pcnext got=%h/%h exp=00000100/0", pc_next, pc_freeze); end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 32'h0, c == 2);
      total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h20) begin
        bad++; $display("FAIL bw_drop_addr c=%0d got=%h/%h exp=1/00000020", c, imem_bus.imem_req, imem_bus.imem_addr); end
      total++; if (pc_freeze !== 1'b1) begin bad++; $display("FAIL bw_freeze c=%0d got=%h exp=1", c, pc_freeze); end
      tick();
      total++; if (valid_out !== 1'b0 || pc !== 32'h100) begin
        bad++; $display("FAIL bw_state c=%0d got=%h/%h exp=0/00000100", c, valid_out, pc); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (imem_bus.imem_addr !== 32'h100) begin bad++; $display("FAIL bw_new_addr got=%h exp=00000100", imem_bus.imem_addr); end
    tick();
    total++; if (valid_out !== 1'b1 || instr_out !== mem_word(32'h100) || pc_plus_out !== 32'h104) begin
      bad++; $display("FAIL bw_target got=%h/%h/%h", valid_out, instr_out, pc_plus_out); end
  endtask

  task automatic test_branch_hazard_full();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    total++; if (imem_bus.imem_req !== 1'b0 || pc_freeze !== 1'b0 || pc_next !== 32'h200) begin
      bad++; $display("FAIL bhf_comb got=%h/%h/%h exp=0/0/00000200", imem_bus.imem_req, pc_freeze, pc_next); end
    tick();
    total++; if (valid_out !== 1'b0 || instr_out !== 32'h0 || pc !== 32'h200) begin
      bad++; $display("FAIL bhf_flush got=%h/%h/%h exp=0/0/00000200", valid_out, instr_out, pc); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (imem_bus.imem_addr !== 32'h200) begin bad++; $display("FAIL bhf_addr got=%h exp=00000200", imem_bus.imem_addr); end
    tick();
    total++; if (valid_out !== 1'b1 || instr_out !== mem_word(32'h200) || pc_plus_out !== 32'h204) begin
      bad++; $display("FAIL bhf_target got=%h/%h/%h", valid_out, instr_out, pc_plus_out); end
  endtask

  task automatic test_wrap_and_reset();
    pc = 32'hFFFF_FFFC;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (pc_next !== 32'h0 || pc_freeze !== 1'b0) begin
      bad++; $display("FAIL wrap_pcnext got=%h/%h exp=0/0", pc_next, pc_freeze); end
    tick();
    total++; if (pc_plus_out !== 32'h0 || instr_out !== mem_word(32'hFFFF_FFFC) || valid_out !== 1'b1) begin
      bad++; $display("FAIL wrap_ifid got=%h/%h/%h", pc_plus_out, instr_out, valid_out); end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    total++; if (imem_bus.imem_req !== 1'b1) begin bad++; $display("FAIL mid_req_pre got=%h exp=1", imem_bus.imem_req); end
    rst = 1'b0;
    #1;
    total++; if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h0) begin
      bad++; $display("FAIL mid_rst_bus got=%h/%h exp=0/0", imem_bus.imem_req, imem_bus.imem_addr); end
    total++; if (valid_out !== 1'b0 || instr_out !== 32'h0 || pc_plus_out !== 32'h0) begin
      bad++; $display("FAIL mid_rst_ifid got=%h/%h/%h exp=0/0/0", valid_out, instr_out, pc_plus_out); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    pc  = 32'h0;
  endtask

  // Model: exp_pc is the address of the next instruction owed to ID in
  // program order. Branches redirect it; each delivery consumes one word.
  task automatic test_random();
    logic [31:0] exp_pc, hold_addr, p_instr, p_plus, ba, want_next;
    logic        p_valid, br, hz, ack, outstanding, last_br;
    int          wait_cnt, deliveries;
    do_reset();
    exp_pc = 32'h0; hold_addr = 32'h0; outstanding = 1'b0; last_br = 1'b0;
    wait_cnt = 0; deliveries = 0;
    for (int n = 0; n < 2000; n++) begin
      hz = ($urandom_range(0, 3) == 0);
      br = !last_br && ($urandom_range(0, 19) == 0);
      ba = $urandom & 32'hFFFF_FFFC;
      hazard = hz; branch_taken = br; branch_addr = br ? ba : 32'h0;
      #1;
      ack = 1'b0;
      if (imem_bus.imem_req) begin
        if (!outstanding) begin
          outstanding = 1'b1; wait_cnt = $urandom_range(0, 3); hold_addr = imem_bus.imem_addr;
        end else begin
          total++; if (imem_bus.imem_addr !== hold_addr) begin
            bad++; $display("FAIL rnd_addr_stable n=%0d got=%h exp=%h", n, imem_bus.imem_addr, hold_addr); end
        end
        if (wait_cnt == 0) begin ack = 1'b1; outstanding = 1'b0; end
        else wait_cnt--;
      end else if (outstanding) begin
        total++; bad++; $display("FAIL rnd_req_dropped n=%0d got=0 exp=1", n);
        outstanding = 1'b0;
      end
      imem_bus.imem_ack   = ack;
      imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
      #1;
      want_next = br ? ba : pc + 32'd4;
      total++; if (pc_next !== want_next) begin bad++; $display("FAIL rnd_pc_next n=%0d got=%h exp=%h", n, pc_next, want_next); end
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, exp_pc); end
      p_instr = instr_out; p_plus = pc_plus_out; p_valid = valid_out;
      tick();
      if (br) begin
        exp_pc = ba;
        total++; if (valid_out !== 1'b0 || instr_out !== 32'h0 || pc_plus_out !== p_plus) begin
          bad++; $display("FAIL rnd_flush n=%0d got=%h/%h/%h", n, valid_out, instr_out, pc_plus_out); end
      end else if (hz) begin
        total++; if (valid_out !== p_valid || instr_out !== p_instr || pc_plus_out !== p_plus) begin
          bad++; $display("FAIL rnd_hold n=%0d got=%h/%h/%h exp=%h/%h/%h", n, valid_out, instr_out, pc_plus_out, p_valid, p_instr, p_plus); end
      end else if (valid_out) begin
        deliveries++;
        total++; if (instr_out !== mem_word(exp_pc) || pc_plus_out !== exp_pc + 32'd4) begin
          bad++; $display("FAIL rnd_deliver n=%0d got=%h/%h exp=%h/%h", n, instr_out, pc_plus_out, mem_word(exp_pc), exp_pc + 32'd4); end
        exp_pc = exp_pc + 32'd4;
      end else begin
        total++; if (instr_out !== p_instr || pc_plus_out !== p_plus) begin
          bad++; $display("FAIL rnd_bubble n=%0d got=%h/%h exp=%h/%h", n, instr_out, pc_plus_out, p_instr, p_plus); end
      end
      last_br = br;
    end
    total++; if (deliveries < 150) begin bad++; $display("FAIL rnd_progress got=%0d exp>=150", deliveries); end
  endtask

  initial begin
    rst = 1'b0; pc = 32'h0; hazard = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_hazard_buffer();
    test_branch_wait();
    test_branch_hazard_full();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
